mnist_stream_classifier: RTL
============================

Name: mnist_stream_classifier

Overview:
Parametrised successor to the fixed mnist_top classifier. Streams pixels through a valid/ready handshake and fetches one row of per-class weights per pixel from an external synchronous memory. Runs NUM_CLASSES signed MACs in parallel, then a sequential argmax that returns the predicted class and its score. Sits between the pixel source (UART/IO deserialiser) and the result/IO logic.

Parameters:
NUM_PIXELS, 784, pixels per image; must be 2 or more.
PIXEL_BITS, 2, unsigned pixel width.
NUM_CLASSES, 10, output classes; must be 2 or more.
WEIGHT_BITS, 8, signed two's-complement weight width.
ACC_BITS, 20, signed accumulator/score width; the integrator sizes it for no overflow.
Derived localparams: ADDR_BITS = clog2(NUM_PIXELS), CLASS_BITS = clog2(NUM_CLASSES).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin an image; sampled only in IDLE.
abort  in  1  synchronous abort; return to IDLE with no done.
pixel_in  in  PIXEL_BITS  pixel data.
pixel_valid  in  1  pixel_in valid.
pixel_ready  out  1  block accepts a pixel.
weight_addr  out  ADDR_BITS  pixel index for the weight row.
weight_rd_en  out  1  weight memory read strobe.
weight_data  in  NUM_CLASSES*WEIGHT_BITS  row returned 1 cycle after weight_rd_en; class c at [c*WEIGHT_BITS +: WEIGHT_BITS].
busy  out  1  high in LOAD, DRAIN and ARGMAX.
done  out  1  one-cycle pulse; result valid.
prediction  out  CLASS_BITS  argmax class index.
score  out  ACC_BITS  signed accumulator of the winning class.

Behaviour:
- Reset (async): state=IDLE; pixel counter, accumulators, done, busy, pixel_ready, weight_rd_en, prediction and score all 0.
- FSM states: IDLE, LOAD, DRAIN, ARGMAX, DONE.
- IDLE: on start, clear all accumulators and the pixel counter, then go to LOAD. While busy, start is ignored. start during the DONE cycle is also ignored.
- LOAD:
  - pixel_ready=1. weight_addr = pixel counter (combinational). weight_rd_en = pixel_valid & pixel_ready.
  - On accept: register the pixel, increment the counter, and arm the MAC for the next cycle.
  - MAC: acc[c] += pixel (zero-extended) * weight[c] (signed), for all c in the same cycle. Accumulation wraps modulo 2^ACC_BITS.
  - Bubbles on pixel_valid are allowed.
  - After accept number NUM_PIXELS, go to DRAIN.
- DRAIN: one cycle; performs the final MAC. pixel_ready=0. Then go to ARGMAX.
- ARGMAX: NUM_CLASSES cycles.
  - Cycle k=0 loads best=acc[0], idx=0.
  - Cycles k=1..C-1 replace best/idx only if acc[k] > best (signed). Ties keep the lowest index.
  - Then go to DONE.
- DONE: one cycle. done=1; prediction/score registered from idx/best. Then go to IDLE.
- prediction and score hold until the next DONE or reset.
- Latency: with pixel_valid held high, done rises NUM_PIXELS+NUM_CLASSES+2 rising edges after the edge that sampled start. Each bubble cycle adds 1.
- abort: in LOAD, DRAIN or ARGMAX, go to IDLE next edge. No done. prediction/score unchanged. Any in-flight MAC is discarded. In IDLE or DONE, abort has no effect.
- If start and abort are both high in IDLE, start wins.
- Async rst mid-operation: immediate IDLE with all reset values.

Decomposition:
- Package mnist_pkg holds:
  - the state enum (IDLE/LOAD/DRAIN/ARGMAX/DONE);
  - the default parameter constants;
  - a clog2 function.
- Sub-module mnist_argmax: sequential signed argmax over a packed accumulator vector, with start/done, lowest-index tie-break. The top holds the FSM, the counter and the MAC array.

Test Plan:
All tests use NUM_PIXELS=4, NUM_CLASSES=3, PIXEL_BITS=2, WEIGHT_BITS=8, ACC_BITS=12, and a bench weight model with 1-cycle read latency.
1. Reset: assert rst mid-clock -> immediately done=0, busy=0, pixel_ready=0, prediction=0, score=0.
2. Basic: pixels 3,1,0,2 back-to-back; weights class0=0, class1=+1, class2=-1 for all rows -> prediction=1, score=6; done for exactly 1 cycle, 9 edges after start; busy low afterwards.
3. Signed/tie: all classes' weights -5 with pixels 3,3,3,3 -> prediction=0, score=-60 (0xFC4). With class1 and class2 weights equal and largest -> prediction=1.
4. Backpressure: same stimulus as test 2, with pixel_valid low for 3 cycles between pixels 2 and 3 -> identical result; done 3 cycles later; weight_rd_en pulses exactly 4 times.
5. Abort: abort after 2 accepted pixels -> IDLE next edge, no done, previous prediction/score held. A new start with the test 2 stimulus -> prediction=1, score=6, confirming accumulators are cleared.
6. Robustness: start pulses during LOAD and ARGMAX are ignored (single done). rst during ARGMAX -> IDLE with all outputs 0; the next full run is correct.

Source files
------------

// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared types, default sizes and helpers for the streaming MNIST classifier
package mnist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_ARGMAX,
    S_DONE
  } state_t;

  localparam int DEF_NUM_PIXELS  = 784;
  localparam int DEF_PIXEL_BITS  = 2;
  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_WEIGHT_BITS = 8;
  localparam int DEF_ACC_BITS    = 20;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mnist_stream_classifier_if.sv
// rtl/mnist_stream_classifier_if.sv - pixel stream and weight-row memory bus of the classifier
interface mnist_stream_classifier_if import mnist_pkg::*; #(
  parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
  parameter int PIXEL_BITS  = DEF_PIXEL_BITS,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int WEIGHT_BITS = DEF_WEIGHT_BITS
);

  logic [PIXEL_BITS-1:0]              pixel_in;
  logic                               pixel_valid;
  logic                               pixel_ready;
  logic [clog2(NUM_PIXELS)-1:0]       weight_addr;
  logic                               weight_rd_en;
  logic [NUM_CLASSES*WEIGHT_BITS-1:0] weight_data;

  modport master (
    output pixel_in, pixel_valid, weight_data,
    input  pixel_ready, weight_addr, weight_rd_en
  );

  modport slave (
    input  pixel_in, pixel_valid, weight_data,
    output pixel_ready, weight_addr, weight_rd_en
  );

endinterface

// File: rtl/mnist_argmax.sv
// rtl/mnist_argmax.sv - sequential signed argmax over a packed accumulator vector, lowest index wins ties
module mnist_argmax import mnist_pkg::*; #(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int ACC_BITS    = DEF_ACC_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [NUM_CLASSES*ACC_BITS-1:0] acc,
  output logic                            running,
  output logic                            done,
  output logic [clog2(NUM_CLASSES)-1:0]   idx,
  output logic [ACC_BITS-1:0]             best
);

  localparam int CLASS_BITS = clog2(NUM_CLASSES);
  localparam logic [CLASS_BITS-1:0] LAST = CLASS_BITS'(NUM_CLASSES - 1);

  logic [CLASS_BITS-1:0] k;
  logic [ACC_BITS-1:0]   cand;

  assign cand = acc[int'(k)*ACC_BITS +: ACC_BITS];
  assign done = running && (k == LAST);

  // start is the k=0 cycle; each following cycle compares one more class
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      k       <= '0;
      idx     <= '0;
      best    <= '0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      best    <= acc[ACC_BITS-1:0];
      idx     <= '0;
      k       <= CLASS_BITS'(1);
      running <= 1'b1;
    end else if (running) begin
      if ($signed(cand) > $signed(best)) begin
        best <= cand;
        idx  <= k;
      end
      if (k == LAST) running <= 1'b0;
      else           k       <= k + CLASS_BITS'(1);
    end
  end

endmodule

// File: rtl/mnist_stream_classifier.sv
// rtl/mnist_stream_classifier.sv - streaming linear classifier: parallel signed MACs per pixel, then argmax
module mnist_stream_classifier import mnist_pkg::*; #(
  parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
  parameter int PIXEL_BITS  = DEF_PIXEL_BITS,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int WEIGHT_BITS = DEF_WEIGHT_BITS,
  parameter int ACC_BITS    = DEF_ACC_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  mnist_stream_classifier_if.slave      stream,
  output logic                          busy,
  output logic                          done,
  output logic [clog2(NUM_CLASSES)-1:0] prediction,
  output logic [ACC_BITS-1:0]           score
);

  localparam int ADDR_BITS  = clog2(NUM_PIXELS);
  localparam int CLASS_BITS = clog2(NUM_CLASSES);
  localparam int ACC_VEC    = NUM_CLASSES * ACC_BITS;

  state_t                 state, state_n;
  logic [ADDR_BITS-1:0]   cnt;
  logic [PIXEL_BITS-1:0]  pix_q;
  logic                   mac_en;
  logic                   accept;
  logic [ACC_VEC-1:0]     acc, acc_sum;
  logic [ACC_BITS-1:0]    pix_ext, w_ext;
  logic                   am_start, am_running, am_done;
  logic [CLASS_BITS-1:0]  am_idx;
  logic [ACC_BITS-1:0]    am_best;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n             = state;
    busy                = 1'b0;
    accept              = 1'b0;
    am_start            = 1'b0;
    stream.pixel_ready  = 1'b0;
    stream.weight_rd_en = 1'b0;
    stream.weight_addr  = cnt;
    case (state)
      S_IDLE: if (start) state_n = S_LOAD;
      S_LOAD: begin
        busy                = 1'b1;
        stream.pixel_ready  = 1'b1;
        accept              = stream.pixel_valid;
        stream.weight_rd_en = stream.pixel_valid;
        if (abort) state_n = S_IDLE;
        else if (accept && cnt == ADDR_BITS'(NUM_PIXELS - 1)) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_n = abort ? S_IDLE : S_ARGMAX;
      end
      S_ARGMAX: begin
        busy     = 1'b1;
        am_start = !am_running;
        if (abort)        state_n = S_IDLE;
        else if (am_done) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // operands widened to ACC_BITS so the product and sum wrap modulo 2^ACC_BITS
  always_comb begin
    acc_sum = '0;
    w_ext   = '0;
    pix_ext = ACC_BITS'(pix_q);
    for (int c = 0; c < NUM_CLASSES; c++) begin
      w_ext = ACC_BITS'($signed(stream.weight_data[c*WEIGHT_BITS +: WEIGHT_BITS]));
      acc_sum[c*ACC_BITS +: ACC_BITS] = acc[c*ACC_BITS +: ACC_BITS] + pix_ext * w_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      pix_q      <= '0;
      mac_en     <= 1'b0;
      acc        <= '0;
      done       <= 1'b0;
      prediction <= '0;
      score      <= '0;
    end else begin
      done   <= (state == S_DONE);
      mac_en <= accept && !abort;
      if (state == S_IDLE && start) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        if (accept) begin
          pix_q <= stream.pixel_in;
          cnt   <= cnt + ADDR_BITS'(1);
        end
        if (mac_en) acc <= acc_sum;
      end
      if (state == S_DONE) begin
        prediction <= am_idx;
        score      <= am_best;
      end
    end
  end

  mnist_argmax #(
    .NUM_CLASSES (NUM_CLASSES),
    .ACC_BITS    (ACC_BITS)
  ) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .start   (am_start),
    .abort   (abort),
    .acc     (acc),
    .running (am_running),
    .done    (am_done),
    .idx     (am_idx),
    .best    (am_best)
  );

endmodule
